// File: rtl/logic_issue_if.sv
// Command, logic-unit and response bundle for logic_issue.
// The slave side is the issue block; the master side feeds commands and hosts the logic unit.
interface logic_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_tag;

  logic [31:0] logic_a;
  logic [31:0] logic_b;
  logic [3:0]  logic_op;
  logic [31:0] logic_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_zero;

  logic [2:0]  fifo_count;
  logic [15:0] done_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, logic_result, rsp_ready,
    input  cmd_ready, logic_a, logic_b, logic_op, rsp_valid, rsp_data, rsp_tag, rsp_zero,
    input  fifo_count, done_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, logic_result, rsp_ready,
    output cmd_ready, logic_a, logic_b, logic_op, rsp_valid, rsp_data, rsp_tag, rsp_zero,
    output fifo_count, done_count
  );
endinterface

// File: rtl/logic_issue.sv
// Command FIFO feeding a two-stage issue pipeline around an external combinational logic unit.
// S1 presents registered operands to the unit; S2 captures its result as the response.
module logic_issue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  logic_issue_if.slave  bus
);

  localparam logic [2:0] Full = 3'(DEPTH);

  // FIFO storage; contents need no reset since count gates every read.
  logic [31:0] memA   [DEPTH];
  logic [31:0] memB   [DEPTH];
  logic [3:0]  memOp  [DEPTH];
  logic [3:0]  memTag [DEPTH];

  logic [1:0]  wrPtr_q, rdPtr_q;
  logic [2:0]  count_q, count_d;
  logic        readyEn_q;

  logic        s1Valid_q;
  logic [31:0] logicA_q, logicB_q;
  logic [3:0]  logicOp_q, s1Tag_q;

  logic        rspValid_q;
  logic [31:0] rspData_q;
  logic [3:0]  rspTag_q;
  logic [15:0] doneCount_q;

  logic        cmdReady;
  logic        push, pop;
  logic        fifoEmpty;
  logic        s1Adv, s1Load;
  logic        rspHs;

  // Ready depends only on registered state; readyEn_q keeps it low through reset.
  always_comb begin
    cmdReady  = readyEn_q && (count_q < Full);
    push      = bus.cmd_valid && cmdReady;
    fifoEmpty = (count_q == 3'd0);
    s1Adv     = s1Valid_q && (!rspValid_q || bus.rsp_ready);
    s1Load    = !fifoEmpty && (!s1Valid_q || s1Adv);
    pop       = s1Load;
    rspHs     = rspValid_q && bus.rsp_ready;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memA[wrPtr_q]   <= bus.cmd_a;
      memB[wrPtr_q]   <= bus.cmd_b;
      memOp[wrPtr_q]  <= bus.cmd_op;
      memTag[wrPtr_q] <= bus.cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q     <= 2'd0;
      rdPtr_q     <= 2'd0;
      count_q     <= 3'd0;
      readyEn_q   <= 1'b0;
      s1Valid_q   <= 1'b0;
      logicA_q    <= 32'd0;
      logicB_q    <= 32'd0;
      logicOp_q   <= 4'd0;
      s1Tag_q     <= 4'd0;
      rspValid_q  <= 1'b0;
      rspData_q   <= 32'd0;
      rspTag_q    <= 4'd0;
      doneCount_q <= 16'd0;
    end else begin
      readyEn_q <= 1'b1;
      count_q   <= count_d;
      if (push) wrPtr_q <= wrPtr_q + 2'd1;
      if (pop)  rdPtr_q <= rdPtr_q + 2'd1;

      // Operands only change on a load so the logic unit sees stable inputs when idle.
      if (s1Load) begin
        s1Valid_q <= 1'b1;
        logicA_q  <= memA[rdPtr_q];
        logicB_q  <= memB[rdPtr_q];
        logicOp_q <= memOp[rdPtr_q];
        s1Tag_q   <= memTag[rdPtr_q];
      end else if (s1Adv) begin
        s1Valid_q <= 1'b0;
      end

      if (s1Adv) begin
        rspValid_q <= 1'b1;
        rspData_q  <= bus.logic_result;
        rspTag_q   <= s1Tag_q;
      end else if (bus.rsp_ready) begin
        rspValid_q <= 1'b0;
      end

      if (rspHs) doneCount_q <= doneCount_q + 16'd1;
    end
  end

  assign bus.cmd_ready  = cmdReady;
  assign bus.logic_a    = logicA_q;
  assign bus.logic_b    = logicB_q;
  assign bus.logic_op   = logicOp_q;
  assign bus.rsp_valid  = rspValid_q;
  assign bus.rsp_data   = rspData_q;
  assign bus.rsp_tag    = rspTag_q;
  assign bus.rsp_zero   = (rspData_q == 32'd0);
  assign bus.fifo_count = count_q;
  assign bus.done_count = doneCount_q;

endmodule

// File: tb/tb_logic_issue.sv
// Directed bench for logic_issue; a stub logic unit computes A|B or A&B.
module tb_logic_issue;

  logic clk;
  logic rst_n;
  logic useAnd;
  int   nChecks;
  int   nErrors;

  logic_issue_if bus ();

  logic_issue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.logic_result = useAnd ? (bus.logic_a & bus.logic_b) : (bus.logic_a | bus.logic_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = 4'h6;
    bus.cmd_tag   = tag;
  endtask

  initial begin
    int acc;
    int stale;
    int budget;
    logic [31:0] heldData;

    nChecks = 0;
    nErrors = 0;
    useAnd  = 1'b0;
    rst_n   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    checkVal("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkVal("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    checkVal("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkVal("rst_done_count", 32'(bus.done_count), 32'd0);
    checkVal("rst_rsp_zero", 32'(bus.rsp_zero), 32'd1);
    checkVal("rst_logic_a", bus.logic_a, 32'd0);
    checkVal("rst_rsp_data", bus.rsp_data, 32'd0);
    rst_n = 1'b1;
    tick();
    checkVal("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single op latency
    bus.rsp_ready = 1'b1;
    drive(32'h0000_00F0, 32'h0000_000F, 4'd3);
    tick();
    bus.cmd_valid = 1'b0;
    checkVal("single_fifo_count", 32'(bus.fifo_count), 32'd1);
    checkVal("single_n1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkVal("single_logic_a", bus.logic_a, 32'h0000_00F0);
    checkVal("single_logic_b", bus.logic_b, 32'h0000_000F);
    checkVal("single_logic_op", 32'(bus.logic_op), 32'h6);
    checkVal("single_n2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkVal("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkVal("single_rsp_data", bus.rsp_data, 32'h0000_00FF);
    checkVal("single_rsp_tag", 32'(bus.rsp_tag), 32'd3);
    checkVal("single_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    tick();
    checkVal("single_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    checkVal("single_done", 32'(bus.done_count), 32'd1);
    checkVal("single_logic_hold", bus.logic_a, 32'h0000_00F0);

    // Streaming
    doReset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(32'(k), 32'(k) << 4, 4'(k));
      else bus.cmd_valid = 1'b0;
      tick();
      checkVal("stream_valid", 32'(bus.rsp_valid), 32'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) begin
        checkVal("stream_tag", 32'(bus.rsp_tag), 32'(k - 2));
        checkVal("stream_data", bus.rsp_data, 32'(k - 2) | (32'(k - 2) << 4));
      end
    end
    checkVal("stream_done", 32'(bus.done_count), 32'd8);

    // Backpressure
    doReset();
    bus.rsp_ready = 1'b0;
    acc = 0;
    while (bus.cmd_ready && acc < 20) begin
      drive(32'h100 + 32'(acc), 32'd0, 4'(acc));
      tick();
      acc++;
    end
    bus.cmd_valid = 1'b0;
    checkVal("bp_accepts", 32'(acc), 32'd6);
    checkVal("bp_fifo_count", 32'(bus.fifo_count), 32'd4);
    checkVal("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkVal("bp_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    heldData = bus.rsp_data;
    tick();
    tick();
    checkVal("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    checkVal("bp_hold_data", bus.rsp_data, 32'h100);
    checkVal("bp_hold_stable", bus.rsp_data, heldData);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkVal("drain_valid", 32'(bus.rsp_valid), 32'd1);
      checkVal("drain_tag", 32'(bus.rsp_tag), 32'(i));
      checkVal("drain_data", bus.rsp_data, 32'h100 + 32'(i));
      tick();
    end
    checkVal("drain_empty", 32'(bus.rsp_valid), 32'd0);
    checkVal("drain_fifo", 32'(bus.fifo_count), 32'd0);
    checkVal("drain_done", 32'(bus.done_count), 32'd6);

    // Zero flag
    useAnd = 1'b1;
    drive(32'hFFFF_0000, 32'h0000_FFFF, 4'd5);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    checkVal("zero_valid", 32'(bus.rsp_valid), 32'd1);
    checkVal("zero_data", bus.rsp_data, 32'd0);
    checkVal("zero_flag", 32'(bus.rsp_zero), 32'd1);
    checkVal("zero_tag", 32'(bus.rsp_tag), 32'd5);
    tick();
    useAnd = 1'b0;

    // Reset mid-flight: S2, S1 and three FIFO entries occupied
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h200 + 32'(i), 32'd0, 4'(i));
      tick();
    end
    bus.cmd_valid = 1'b0;
    checkVal("mid_fifo_before", 32'(bus.fifo_count), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkVal("mid_fifo", 32'(bus.fifo_count), 32'd0);
    checkVal("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkVal("mid_done", 32'(bus.done_count), 32'd0);
    checkVal("mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid) stale++;
    end
    checkVal("mid_stale", 32'(stale), 32'd0);
    checkVal("mid_ready_back", 32'(bus.cmd_ready), 32'd1);

    // done_count wrap through real handshakes
    doReset();
    bus.rsp_ready = 1'b1;
    drive(32'h1, 32'h0, 4'd1);
    budget = 0;
    while (bus.done_count != 16'hFFFF && budget < 70000) begin
      tick();
      budget++;
    end
    bus.cmd_valid = 1'b0;
    checkVal("wrap_reach", 32'(bus.done_count), 32'hFFFF);
    checkVal("wrap_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    checkVal("wrap_zero", 32'(bus.done_count), 32'h0000);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
